mips_cpu_muldiv: RTL and testbench
==================================

# mips_cpu_muldiv

Iterative multiply/divide unit that owns the architectural Hi/Lo registers and services MULT, MULTU, DIV, DIVU, MTHI and MTLO requests issued by control. Each request is a single-cycle start pulse; control stalls on `busy`. The unit sits beside the single-cycle ALU in the execute stage. Multiplies and divides run as a 32-iteration shift/add or shift/subtract sequence instead of a combinational `*`, `/` or `%`.

## Interface
- None. Datapath width is fixed at 32 bits.

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  request strobe; accepted only when `busy`=0
- `op`  in  3  request type, encoded `muldiv_op_t`
- `a`  in  32  rs operand; multiplicand, dividend, or MTHI/MTLO source
- `b`  in  32  rt operand; multiplier or divisor
- `busy`  out  1  operation in progress; control stalls MFHI, MFLO and new requests
- `done`  out  1  one-cycle pulse when Hi/Lo receive a MULT/DIV result
- `hi`  out  32  architectural Hi register
- `lo`  out  32  architectural Lo register

## Operation
- Op encodings:
  - MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - Codes 6 and 7 are ignored: no state change and no `done`.
- FSM states and transitions:
  - IDLE → CALC when `start` arrives with a MULT/DIV op.
  - CALC runs 32 iterations, counter 0..31, then goes to FIX.
  - FIX → IDLE.
- Accept in IDLE:
  - Latch |a| and |b| as magnitudes for signed ops, raw values for unsigned ops.
  - Latch result sign flags for quotient/product and remainder.
  - Clear the accumulator.
- Multiply:
  - Radix-2 shift-add on magnitudes into a 64-bit accumulator.
  - FIX negates the 64-bit product when sign(a) XOR sign(b) for MULT.
- Divide:
  - Restoring division on magnitudes.
  - FIX negates the quotient when sign(a) XOR sign(b).
  - FIX negates the remainder when sign(a)=1, so the remainder takes the dividend's sign.
- Divide by zero (defined, not trapped):
  - `lo`=32'hFFFFFFFF, `hi`=a for both DIV and DIVU.
  - For DIV this is the raw a, not its magnitude.
- DIV 32'h80000000 / 32'hFFFFFFFF gives `lo`=32'h80000000, `hi`=0.
- MTHI/MTLO:
  - Write `a` to `hi` or `lo` at the accept edge.
  - The other register is unchanged.
  - `busy` and `done` stay low.
- `hi`/`lo` hold their previous values for the whole of CALC and are written only in FIX or by MT ops.
- `start` while `busy`=1 is ignored. No queueing; control guarantees this does not happen.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE.
- Reset mid-operation aborts the sequence: next cycle IDLE, Hi/Lo zero, no `done`.

## Timing
- Accept edge E0, for a MULT/DIV op:
  - `busy`=1 from E0 through E33; it drops at E33.
  - Hi/Lo are written at E33.
  - `done`=1 for the single cycle after E33.
- Result latency: 33 cycles from the accept edge to valid `hi`/`lo`.
- `done` and `busy`=0 are coincident. A new `start` may be accepted in that same cycle.
- MTHI/MTLO: new value visible on `hi`/`lo` the cycle after the accept edge.
- `rst` and `start` in the same cycle: `rst` wins.

## Structure
- Package `mips_cpu_muldiv_pkg` holds:
  - `muldiv_op_t` enum, 3 bits;
  - `muldiv_state_t` enum {IDLE, CALC, FIX};
  - `MULDIV_ITERS`=32;
  - `DIV0_QUOT`=32'hFFFFFFFF.
- No sub-module is natural. A single module holds the FSM, 5-bit iteration counter, 64-bit accumulator and 33-bit add/subtract.
- The control decoder imports the same package for `op`.

## Test plan
- MULT a=32'hFFFFFFFD (-3), b=7:
  - Required: `busy` high for 33 cycles.
  - Required: `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFEB.
  - Required: single `done` pulse.
- MULTU a=b=32'hFFFFFFFF:
  - Required: `hi`=32'hFFFFFFFE, `lo`=32'h00000001.
- DIV a=-7, b=2:
  - Required: `lo`=32'hFFFFFFFD, `hi`=32'hFFFFFFFF.
- DIVU a=7, b=0:
  - Required: `lo`=32'hFFFFFFFF, `hi`=7.
- DIV a=32'h80000000, b=32'hFFFFFFFF:
  - Required: `lo`=32'h80000000, `hi`=0.
- MTHI 32'h12345678 in idle:
  - Required: `hi` updates next cycle, `lo` unchanged, no `busy`/`done`.
  - Then start MULTU and pulse `start` with MTLO at cycle 5 of it: required ignored, `lo` reflects only the product.
- `rst` at cycle 10 of a DIV:
  - Required next cycle: `busy`=0, `hi`=`lo`=0.
  - Required: no `done` within 40 cycles.

Source files
------------

// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types and constants for the Hi/Lo multiply/divide unit.
// The control decoder imports this package for the op encoding.
package mips_cpu_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    localparam int          MULDIV_ITERS = 32;
    localparam logic [31:0] DIV0_QUOT    = 32'hFFFFFFFF;

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// Request/result bundle between execute-stage control and the muldiv unit.
interface mips_cpu_muldiv_if;
    import mips_cpu_muldiv_pkg::*;

    logic        start;
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/mips_cpu_muldiv.sv
// Iterative 32-step multiply/divide unit owning the architectural Hi/Lo
// registers. Magnitudes are processed unsigned; signs are applied in FIX.
module mips_cpu_muldiv (
    input logic              clk,
    input logic              rst,
    mips_cpu_muldiv_if.slave bus
);
    import mips_cpu_muldiv_pkg::*;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        return v[31] ? neg32(v) : v;
    endfunction

    muldiv_state_t state;
    logic [4:0]    cnt;
    logic [63:0]   acc;
    logic [31:0]   opa;
    logic [31:0]   opb;
    logic          is_div;
    logic          prod_neg;
    logic          quot_neg;
    logic          rem_neg;
    logic          done_r;
    logic [31:0]   hi_r;
    logic [31:0]   lo_r;

    logic          is_md_op;
    logic          signed_op;
    logic          sign_a;
    logic          sign_b;
    logic          accept_md;
    logic [32:0]   rem_sh;
    logic [33:0]   addsub;
    logic [63:0]   prod;
    logic [31:0]   quot;
    logic [31:0]   rem;

    assign is_md_op  = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                       (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign sign_a    = signed_op & bus.a[31];
    assign sign_b    = signed_op & bus.b[31];
    assign accept_md = (state == IDLE) && bus.start && is_md_op;

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // Shared adder: shift-add partial product, or trial subtract of divisor.
    always_comb begin
        rem_sh = {acc[63:32], opa[31]};
        if (is_div) begin
            addsub = {1'b0, rem_sh} - {2'b00, opb};
        end else begin
            addsub = {2'b00, acc[63:32]} + {2'b00, (opb[0] ? opa : 32'd0)};
        end
    end

    // Sign fix-up of the magnitude results, applied when FIX writes Hi/Lo.
    always_comb begin
        prod = prod_neg ? neg64(acc) : acc;
        quot = quot_neg ? neg32(acc[31:0]) : acc[31:0];
        rem  = rem_neg  ? neg32(acc[63:32]) : acc[63:32];
    end

    // Control: FSM, iteration counter, done pulse and architectural Hi/Lo.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            done_r <= 1'b0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state <= CALC;
                                cnt   <= 5'd0;
                            end
                            OP_MTHI: hi_r <= bus.a;
                            OP_MTLO: lo_r <= bus.a;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (cnt == 5'(MULDIV_ITERS - 1)) begin
                        state <= FIX;
                    end
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    state  <= IDLE;
                    done_r <= 1'b1;
                    if (is_div) begin
                        hi_r <= rem;
                        lo_r <= quot;
                    end else begin
                        hi_r <= prod[63:32];
                        lo_r <= prod[31:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operand latch on accept, then one shift step per CALC cycle.
    // A zero divisor makes every trial subtract succeed, so the quotient
    // comes out all ones and the remainder equals |a|; suppressing the
    // quotient sign and negating the remainder by sign(a) restores raw a.
    always_ff @(posedge clk) begin
        if (accept_md) begin
            opa      <= signed_op ? abs32(bus.a) : bus.a;
            opb      <= signed_op ? abs32(bus.b) : bus.b;
            acc      <= 64'd0;
            is_div   <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
            prod_neg <= sign_a ^ sign_b;
            quot_neg <= (sign_a ^ sign_b) && (bus.b != 32'd0);
            rem_neg  <= sign_a;
        end else if (state == CALC) begin
            if (is_div) begin
                acc <= {(addsub[33] ? rem_sh[31:0] : addsub[31:0]), acc[30:0], ~addsub[33]};
                opa <= {opa[30:0], 1'b0};
            end else begin
                acc <= {addsub[32:0], acc[31:1]};
                opb <= {1'b0, opb[31:1]};
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: hand-computed Hi/Lo results, timing
// of busy/done, MT ops, ignored requests and reset behaviour.
module tb_mips_cpu_muldiv;
    import mips_cpu_muldiv_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mips_cpu_muldiv_if bus();

    mips_cpu_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one MULT/DIV request and observe 40 cycles after the accept edge.
    task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cyc, output int done_cyc, output logic done_busy,
                          output logic [31:0] hi_mid, output logic [31:0] lo_mid);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        busy_cyc  = 0;
        done_cyc  = 0;
        done_busy = 1'b1;
        hi_mid    = 32'hx;
        lo_mid    = 32'hx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                done_cyc++;
                done_busy = bus.busy;
            end
            if (i == 15) begin
                hi_mid = bus.hi;
                lo_mid = bus.lo;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %h want 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %h want 0", bus.done); end
        n_vec++; if (bus.hi !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        n_vec++; if (bus.lo !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    endtask

    task automatic test_mult();
        int bc, dc; logic db; logic [31:0] hm, lm;
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, bc, dc, db, hm, lm);
        n_vec++; if (bc != 33) begin n_err++; $display("FAIL mult_busy_cycles got %0d want 33", bc); end
        n_vec++; if (dc != 1) begin n_err++; $display("FAIL mult_done_pulses got %0d want 1", dc); end
        n_vec++; if (db !== 1'b0) begin n_err++; $display("FAIL mult_done_with_busy got %h want 0", db); end
        n_vec++; if (hm !== 32'd0 || lm !== 32'd0) begin n_err++; $display("FAIL mult_hold_during_calc got %h/%h want 0/0", hm, lm); end
        n_vec++; if (bus.hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
        n_vec++; if (bus.lo !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mult_lo got %h want ffffffeb", bus.lo); end
    endtask

    task automatic test_multu();
        int bc, dc; logic db; logic [31:0] hm, lm;
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dc, db, hm, lm);
        n_vec++; if (hm !== 32'hFFFFFFFF || lm !== 32'hFFFFFFEB) begin n_err++; $display("FAIL multu_hold got %h/%h want ffffffff/ffffffeb", hm, lm); end
        n_vec++; if (bus.hi !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_hi got %h want fffffffe", bus.hi); end
        n_vec++; if (bus.lo !== 32'h00000001) begin n_err++; $display("FAIL multu_lo got %h want 00000001", bus.lo); end
    endtask

    task automatic test_div();
        int bc, dc; logic db; logic [31:0] hm, lm;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, bc, dc, db, hm, lm);
        n_vec++; if (bc != 33 || dc != 1) begin n_err++; $display("FAIL div_timing got busy %0d done %0d want 33 1", bc, dc); end
        n_vec++; if (bus.lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo got %h want fffffffd", bus.lo); end
        n_vec++; if (bus.hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi got %h want ffffffff", bus.hi); end
        run_op(OP_DIVU, 32'd100, 32'd7, bc, dc, db, hm, lm);
        n_vec++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin n_err++; $display("FAIL divu_100_7 got lo %h hi %h want 0000000e 00000002", bus.lo, bus.hi); end
    endtask

    task automatic test_div_zero();
        int bc, dc; logic db; logic [31:0] hm, lm;
        run_op(OP_DIVU, 32'd7, 32'd0, bc, dc, db, hm, lm);
        n_vec++; if (bus.lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divu0_lo got %h want ffffffff", bus.lo); end
        n_vec++; if (bus.hi !== 32'd7) begin n_err++; $display("FAIL divu0_hi got %h want 00000007", bus.hi); end
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, bc, dc, db, hm, lm);
        n_vec++; if (bus.lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div0_lo got %h want ffffffff", bus.lo); end
        n_vec++; if (bus.hi !== 32'hFFFFFFF9) begin n_err++; $display("FAIL div0_hi got %h want fffffff9", bus.hi); end
    endtask

    task automatic test_div_overflow();
        int bc, dc; logic db; logic [31:0] hm, lm;
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, bc, dc, db, hm, lm);
        n_vec++; if (bus.lo !== 32'h80000000) begin n_err++; $display("FAIL divovf_lo got %h want 80000000", bus.lo); end
        n_vec++; if (bus.hi !== 32'd0) begin n_err++; $display("FAIL divovf_hi got %h want 0", bus.hi); end
    endtask

    task automatic test_mt();
        int dc, k;
        // Lo is 80000000 and Hi is 0 from the previous test.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'h12345678; bus.b = 32'd0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.hi !== 32'h12345678) begin n_err++; $display("FAIL mthi_hi got %h want 12345678", bus.hi); end
        n_vec++; if (bus.lo !== 32'h80000000) begin n_err++; $display("FAIL mthi_lo got %h want 80000000", bus.lo); end
        dc = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.busy || bus.done) dc++;
            @(negedge clk);
        end
        n_vec++; if (dc != 0) begin n_err++; $display("FAIL mthi_busy_done got %0d active cycles want 0", dc); end
        // MULTU 3*5, with an MTLO pulsed at cycle 5 that must be ignored.
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MTLO; bus.a = 32'hDEADBEEF;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.lo !== 32'h80000000) begin n_err++; $display("FAIL mtlo_busy_ignored got %h want 80000000", bus.lo); end
        k = 0;
        while (!bus.done && k < 60) begin @(negedge clk); k++; end
        n_vec++; if (!bus.done) begin n_err++; $display("FAIL mt_multu_timeout got no done want done"); end
        n_vec++; if (bus.lo !== 32'd15 || bus.hi !== 32'd0) begin n_err++; $display("FAIL mt_multu_result got lo %h hi %h want 0000000f 00000000", bus.lo, bus.hi); end
    endtask

    task automatic test_ignored_ops();
        // Codes 6/7 do nothing; rst beats a coincident start.
        @(negedge clk);
        bus.start = 1'b1; bus.op = muldiv_op_t'(3'd6); bus.a = 32'h55555555; bus.b = 32'd1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL op6_busy_done got %h %h want 0 0", bus.busy, bus.done); end
        n_vec++; if (bus.lo !== 32'd15 || bus.hi !== 32'd0) begin n_err++; $display("FAIL op6_hilo got lo %h hi %h want 0000000f 00000000", bus.lo, bus.hi); end
        bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'hAAAA5555; rst = 1'b1;
        @(posedge clk);
        #1 begin bus.start = 1'b0; rst = 1'b0; end
        @(negedge clk);
        n_vec++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin n_err++; $display("FAIL rst_vs_start got hi %h lo %h want 0 0", bus.hi, bus.lo); end
    endtask

    task automatic test_reset_mid_op();
        int dc;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MTLO; bus.a = 32'h0000BEEF;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %h want 0", bus.busy); end
        n_vec++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin n_err++; $display("FAIL midrst_hilo got hi %h lo %h want 0 0", bus.hi, bus.lo); end
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dc++;
            @(negedge clk);
        end
        n_vec++; if (dc != 0) begin n_err++; $display("FAIL midrst_done got %0d pulses want 0", dc); end
    endtask

    task automatic test_back_to_back();
        int k;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd6; bus.b = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < 60) begin @(negedge clk); k++; end
        n_vec++; if (!bus.done || bus.busy) begin n_err++; $display("FAIL b2b_first_done got done %h busy %h want 1 0", bus.done, bus.busy); end
        n_vec++; if (bus.lo !== 32'd42 || bus.hi !== 32'd0) begin n_err++; $display("FAIL b2b_first got lo %h hi %h want 0000002a 0", bus.lo, bus.hi); end
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got busy %h want 1", bus.busy); end
        k = 0;
        while (!bus.done && k < 60) begin @(negedge clk); k++; end
        n_vec++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin n_err++; $display("FAIL b2b_second got lo %h hi %h want 0000000e 00000002", bus.lo, bus.hi); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_div_overflow();
        test_mt();
        test_ignored_ops();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
